// File: rtl/inst_mem_pkg.sv
// Shared constants and loader state type for the instruction memory and its byte loader.
// Optional parity storage is enabled with INST_MEM_PARITY_EN (see inst_mem_loader).
package inst_mem_pkg;

   localparam int NBITS_DEF     = 8;
   localparam int INST_BITS_DEF = 32;
   localparam int CELLS_DEF     = 256;

   localparam logic [INST_BITS_DEF-1:0] HALT_WORD_DEF = {INST_BITS_DEF{1'b1}};

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_LOAD  = 2'd1,
      LD_WRITE = 2'd2,
      LD_DONE  = 2'd3
   } ld_state_e;

endpackage

// File: rtl/inst_mem_byte_asm.sv
// Byte-to-word assembler: shifts bytes in MSB-first and strobes o_word_done on the last byte.
// Zero latency on the strobe; the caller stops shifting while it commits the word.
module inst_mem_byte_asm
   import inst_mem_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int BYTES = INST_BITS_DEF / NBITS_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clr,
   input  logic                   i_shift,
   input  logic [NBITS-1:0]       i_byte,
   output logic [NBITS*BYTES-1:0] o_word,
   output logic                   o_word_done
);

   localparam int W  = NBITS * BYTES;
   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sh_q, sh_d;

   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (i_clr) begin
         cnt_d = '0;
         sh_d  = '0;
      end else if (i_shift) begin
         sh_d  = (sh_q << NBITS) | W'(i_byte);
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

   assign o_word      = sh_q;
   assign o_word_done = i_shift && !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with byte-stream loader; fetch result registered, 1-cycle latency.
// Fetches are refused while the loader is busy; macro INST_MEM_PARITY_EN adds per-cell parity.
module inst_mem_loader
   import inst_mem_pkg::*;
#(
   parameter int NBITS     = NBITS_DEF,
   parameter int INST_BITS = INST_BITS_DEF,
   parameter int CELLS     = CELLS_DEF,
   parameter int ADDR_BITS = 32,
   parameter logic [INST_BITS-1:0] HALT_WORD = {INST_BITS{1'b1}}
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fetch_en,
   input  logic [ADDR_BITS-1:0] i_pc,
   output logic [INST_BITS-1:0] o_inst,
   output logic                 o_inst_valid,
   output logic                 o_misaligned,
   input  logic                 i_ld_start,
   input  logic [NBITS-1:0]     i_ld_byte,
   input  logic                 i_ld_valid,
   output logic                 o_ld_ready,
   output logic                 o_ld_busy,
   output logic                 o_ld_done,
   output logic                 o_ld_ovf,
`ifdef INST_MEM_PARITY_EN
   output logic                 o_parity_err,
`endif
   output logic [ADDR_BITS-1:0] o_ld_words
);

   localparam int BYTES = INST_BITS / NBITS;
   localparam int AW    = $clog2(CELLS);
   localparam logic [AW-1:0]        LAST_PTR = AW'(CELLS - BYTES);
   localparam logic [ADDR_BITS-1:0] BYTES_A  = ADDR_BITS'(BYTES);

   ld_state_e            state_q, state_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] words_q, words_d;
   logic                 done_q, done_d, ovf_q, ovf_d;
   logic [INST_BITS-1:0] inst_q, inst_d;
   logic                 inst_vld_q, inst_vld_d, mis_q, mis_d;
   logic [NBITS-1:0]     mem_q [CELLS];
   logic                 ld_start_ok, ld_xfer, word_done, fetch_ok, fetch_mis;
   logic [INST_BITS-1:0] asm_word, rd_word;
   logic [AW-1:0]        rd_addr;

   assign o_ld_ready  = (state_q == LD_LOAD);
   assign o_ld_busy   = (state_q == LD_LOAD) || (state_q == LD_WRITE);
   assign ld_start_ok = i_ld_start && ((state_q == LD_IDLE) || (state_q == LD_DONE));
   assign ld_xfer     = i_ld_valid && o_ld_ready;
   assign fetch_ok    = i_fetch_en && !o_ld_busy;
   assign rd_addr     = i_pc[AW-1:0];
   assign fetch_mis   = (i_pc % BYTES_A) != '0;

   inst_mem_byte_asm #(.NBITS(NBITS), .BYTES(BYTES)) u_asm (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (ld_start_ok),
      .i_shift     (ld_xfer),
      .i_byte      (i_ld_byte),
      .o_word      (asm_word),
      .o_word_done (word_done)
   );

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      words_d  = words_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      case (state_q)
         LD_IDLE, LD_DONE: begin
            if (i_ld_start) begin
               state_d  = LD_LOAD;
               wr_ptr_d = '0;
               words_d  = '0;
               done_d   = 1'b0;
               ovf_d    = 1'b0;
            end
         end
         LD_LOAD: if (word_done) state_d = LD_WRITE;
         LD_WRITE: begin
            wr_ptr_d = wr_ptr_q + AW'(BYTES);
            words_d  = words_q + 1'b1;
            if (asm_word == HALT_WORD) begin
               state_d = LD_DONE;
               done_d  = 1'b1;
            end else if (wr_ptr_q == LAST_PTR) begin
               state_d = LD_DONE;
               done_d  = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               state_d = LD_LOAD;
            end
         end
         default: state_d = LD_IDLE;
      endcase
   end

   // Read indices wrap modulo CELLS through the AW-bit add.
   always_comb begin
      rd_word = '0;
      for (int b = 0; b < BYTES; b++)
         rd_word[(BYTES-1-b)*NBITS +: NBITS] = mem_q[rd_addr + AW'(b)];
   end

   always_comb begin
      inst_d     = inst_q;
      inst_vld_d = 1'b0;
      mis_d      = mis_q;
      if (fetch_ok) begin
         inst_vld_d = 1'b1;
         mis_d      = fetch_mis;
         inst_d     = fetch_mis ? '0 : rd_word;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= LD_IDLE;
         wr_ptr_q   <= '0;
         words_q    <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         inst_q     <= '0;
         inst_vld_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         words_q    <= words_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         inst_q     <= inst_d;
         inst_vld_q <= inst_vld_d;
         mis_q      <= mis_d;
      end
   end

   // Memory keeps its contents across reset, so no reset branch here.
   always_ff @(posedge i_clk) begin
      if (state_q == LD_WRITE)
         for (int b = 0; b < BYTES; b++)
            mem_q[wr_ptr_q + AW'(b)] <= asm_word[(BYTES-1-b)*NBITS +: NBITS];
   end

`ifdef INST_MEM_PARITY_EN
   logic par_q [CELLS];
   logic par_err_q, par_err_d, rd_par_bad;

   always_ff @(posedge i_clk) begin
      if (state_q == LD_WRITE)
         for (int b = 0; b < BYTES; b++)
            par_q[wr_ptr_q + AW'(b)] <= ^asm_word[(BYTES-1-b)*NBITS +: NBITS];
   end

   always_comb begin
      rd_par_bad = 1'b0;
      for (int b = 0; b < BYTES; b++)
         if ((^mem_q[rd_addr + AW'(b)]) != par_q[rd_addr + AW'(b)]) rd_par_bad = 1'b1;
      par_err_d = fetch_ok ? (rd_par_bad && !fetch_mis) : par_err_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) par_err_q <= 1'b0;
      else          par_err_q <= par_err_d;
   end

   assign o_parity_err = par_err_q;
`endif

   assign o_inst       = inst_q;
   assign o_inst_valid = inst_vld_q;
   assign o_misaligned = mis_q;
   assign o_ld_done    = done_q;
   assign o_ld_ovf     = ovf_q;
   assign o_ld_words   = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of fetch vectors plus randomized loads/fetches against a word-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inst_mem_loader;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_fetch_en = 1'b0;
   logic [31:0] i_pc = '0;
   logic [31:0] o_inst;
   logic        o_inst_valid, o_misaligned;
   logic        i_ld_start = 1'b0;
   logic [7:0]  i_ld_byte = '0;
   logic        i_ld_valid = 1'b0;
   logic        o_ld_ready, o_ld_busy, o_ld_done, o_ld_ovf;
   logic [31:0] o_ld_words;
`ifdef INST_MEM_PARITY_EN
   logic        o_parity_err;
`endif

   inst_mem_loader dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_fetch_en   (i_fetch_en),
      .i_pc         (i_pc),
      .o_inst       (o_inst),
      .o_inst_valid (o_inst_valid),
      .o_misaligned (o_misaligned),
      .i_ld_start   (i_ld_start),
      .i_ld_byte    (i_ld_byte),
      .i_ld_valid   (i_ld_valid),
      .o_ld_ready   (o_ld_ready),
      .o_ld_busy    (o_ld_busy),
      .o_ld_done    (o_ld_done),
      .o_ld_ovf     (o_ld_ovf),
`ifdef INST_MEM_PARITY_EN
      .o_parity_err (o_parity_err),
`endif
      .o_ld_words   (o_ld_words)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   // Word-level reference: byte memory, load pointer, counters.
   logic [7:0]  model_mem [256];
   int          model_ptr, model_words;
   bit          model_done, model_ovf;
   logic [31:0] prog_q [$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } fvec_t;
   fvec_t tbl [6];

   bit   mon_en = 1'b0;
   int   mon_wr_cycles = 0;
   logic prev_busy = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check32({tag, "_inst"}, o_inst, 32'h0);
      check1({tag, "_valid"}, o_inst_valid, 1'b0);
      check1({tag, "_mis"}, o_misaligned, 1'b0);
      check1({tag, "_done"}, o_ld_done, 1'b0);
      check1({tag, "_ovf"}, o_ld_ovf, 1'b0);
      check32({tag, "_words"}, o_ld_words, 32'd0);
      check1({tag, "_ready"}, o_ld_ready, 1'b0);
      check1({tag, "_busy"}, o_ld_busy, 1'b0);
`ifdef INST_MEM_PARITY_EN
      check1({tag, "_perr"}, o_parity_err, 1'b0);
`endif
   endtask

   function automatic logic [31:0] model_fetch(input logic [31:0] pc);
      logic [31:0] r = '0;
      if ((pc % 4) != 0) return 32'h0;
      for (int k = 0; k < 4; k++) r = {r[23:0], model_mem[(pc + k) % 256]};
      return r;
   endfunction

   task automatic model_commit(input logic [31:0] w);
      for (int k = 0; k < 4; k++) model_mem[(model_ptr + k) % 256] = w[31-8*k -: 8];
      model_ptr += 4;
      model_words++;
      if (w == 32'hFFFF_FFFF) model_done = 1'b1;
      else if (model_ptr >= 256) begin
         model_done = 1'b1;
         model_ovf  = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_ld_valid = 1'b1;
      i_ld_byte  = b;
      while (!o_ld_ready && n < 16) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ld_ready) begin
         checks++;
         errors++;
         $display("FAIL ld_ready_timeout: ready=%b expected 1", o_ld_ready);
      end
      @(negedge i_clk);
      i_ld_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge i_clk);
         send_byte(w[31-8*k -: 8]);
      end
      model_commit(w);
   endtask

   task automatic start_load();
      i_ld_start = 1'b1;
      @(negedge i_clk);
      i_ld_start = 1'b0;
      model_ptr   = 0;
      model_words = 0;
      model_done  = 1'b0;
      model_ovf   = 1'b0;
   endtask

   task automatic run_load(input bit gaps);
      start_load();
      foreach (prog_q[i]) begin
         if (model_done) break;
         send_word(prog_q[i], gaps);
      end
      @(negedge i_clk);
      check1("ld_done", o_ld_done, model_done);
      check1("ld_ovf", o_ld_ovf, model_ovf);
      check32("ld_words", o_ld_words, model_words);
   endtask

   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp_inst, input logic exp_mis,
                           input string tag);
      i_fetch_en = 1'b1;
      i_pc       = pc;
      @(negedge i_clk);
      i_fetch_en = 1'b0;
      check1({tag, "_valid"}, o_inst_valid, 1'b1);
      check32({tag, "_inst"}, o_inst, exp_inst);
      check1({tag, "_mis"}, o_misaligned, exp_mis);
      @(negedge i_clk);
      check1({tag, "_hold_valid"}, o_inst_valid, 1'b0);
      check32({tag, "_hold_inst"}, o_inst, exp_inst);
   endtask

   // While the loader stays busy, no fetch may complete; WRITE is the busy-but-not-ready cycle.
   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_ld_busy && !o_ld_ready) mon_wr_cycles++;
         if (o_ld_busy && prev_busy) check1("busy_fetch_blocked", o_inst_valid, 1'b0);
      end
      prev_busy = o_ld_busy;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w, pc;
      int n;

      tbl[0] = '{32'd0,   32'h1234_5678, 1'b0};
      tbl[1] = '{32'd6,   32'h0000_0000, 1'b1};
      tbl[2] = '{32'd4,   32'hFFFF_FFFF, 1'b0};
      tbl[3] = '{32'd2,   32'h0000_0000, 1'b1};
      tbl[4] = '{32'd256, 32'h1234_5678, 1'b0};
      tbl[5] = '{32'd260, 32'hFFFF_FFFF, 1'b0};

      repeat (2) @(negedge i_clk);
      check_reset("reset");
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Two-word program ending in the halt word, then fixed fetch vectors.
      prog_q = '{32'h1234_5678, 32'hFFFF_FFFF};
      run_load(1'b0);
      check32("basic_words", o_ld_words, 32'd2);
      check1("basic_done", o_ld_done, 1'b1);
      check1("basic_ovf", o_ld_ovf, 1'b0);
      foreach (tbl[i]) do_fetch(tbl[i].pc, tbl[i].inst, tbl[i].mis, $sformatf("tbl%0d", i));

      // Fill the whole memory with non-halt words while fetch requests are held high.
      prog_q.delete();
      for (int i = 0; i < 66; i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = 32'h0;
         prog_q.push_back(w);
      end
      i_fetch_en    = 1'b1;
      i_pc          = 32'd0;
      mon_wr_cycles = 0;
      mon_en        = 1'b1;
      run_load(1'b0);
      mon_en     = 1'b0;
      i_fetch_en = 1'b0;
      check32("full_words", o_ld_words, 32'd64);
      check1("full_ovf", o_ld_ovf, 1'b1);
      check1("full_done", o_ld_done, 1'b1);
      check32("full_write_cycles", mon_wr_cycles, 32'd64);
      @(negedge i_clk);
      do_fetch(32'd252, prog_q[63], 1'b0, "last_word");
      do_fetch(32'd256, prog_q[0], 1'b0, "wrap_word");
      for (int i = 0; i < 24; i++) begin
         pc = $urandom;
         if (i % 2 == 0) pc = pc & ~32'd3;
         do_fetch(pc, model_fetch(pc), (pc % 4) != 0, "rand_full");
      end

      // Short random programs terminated by the halt word, with idle gaps between bytes.
      for (int r = 0; r < 3; r++) begin
         prog_q.delete();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1;
            prog_q.push_back(w);
         end
         prog_q.push_back(32'hFFFF_FFFF);
         run_load(1'b1);
         for (int i = 0; i < 6; i++) begin
            pc = $urandom_range(0, 47);
            do_fetch(pc, model_fetch(pc), (pc % 4) != 0, "rand_short");
         end
      end

      // Reset in the middle of the second word: first word stays, partial word is dropped.
      start_load();
      send_word(32'hA1B2_C3D4, 1'b0);
      send_byte(8'h55);
      send_byte(8'h66);
      i_rst_n = 1'b0;
      #1;
      check_reset("midload_reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      do_fetch(32'd0, 32'hA1B2_C3D4, 1'b0, "kept_word");
      do_fetch(32'd4, model_fetch(32'd4), 1'b0, "partial_dropped");
      prog_q = '{32'hCAFE_0042, 32'hFFFF_FFFF};
      run_load(1'b0);
      do_fetch(32'd0, 32'hCAFE_0042, 1'b0, "reload_w0");
      do_fetch(32'd4, 32'hFFFF_FFFF, 1'b0, "reload_w1");

`ifdef INST_MEM_PARITY_EN
      check1("par_clean", o_parity_err, 1'b0);
      dut.mem_q[0] = dut.mem_q[0] ^ 8'h01;
      i_fetch_en = 1'b1;
      i_pc       = 32'd0;
      @(negedge i_clk);
      i_fetch_en = 1'b0;
      check1("par_err_set", o_parity_err, 1'b1);
      do_fetch(32'd4, 32'hFFFF_FFFF, 1'b0, "par_next");
      check1("par_err_clr", o_parity_err, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
